// File: rtl/env_census.sv
// env_census: raster-order census of the environment grid over a shared lookup port.
// Ports:
//   newLocClock, RESET_SIM          clock, async active-high reset
//   start                           begin a census (ignored unless idle)
//   scan_req / scan_gnt             lookup port ownership handshake
//   lookup_X, lookup_Y              address presented to the lookup port
//   lookup_sugar, lookup_signal     data for the address issued READ_LAT cycles earlier
//   busy, done                      census in progress / one-cycle results-valid pulse
//   sugar_count, signal_sum         sugar cell count, total signal
//   max_signal, max_X, max_Y        strongest signal and its first raster location
module env_census #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4,
    parameter int X_DIM       = 160,
    parameter int Y_DIM       = 120,
    parameter int READ_LAT    = 1
) (
    input  logic                      newLocClock,
    input  logic                      RESET_SIM,
    input  logic                      start,
    output logic                      scan_req,
    input  logic                      scan_gnt,
    output logic [X_bits-1:0]         lookup_X,
    output logic [Y_bits-1:0]         lookup_Y,
    input  logic                      lookup_sugar,
    input  logic [SIGNAL_bits-1:0]    lookup_signal,
    output logic                      busy,
    output logic                      done,
    output logic [14:0]               sugar_count,
    output logic [SIGNAL_bits+14:0]   signal_sum,
    output logic [SIGNAL_bits-1:0]    max_signal,
    output logic [X_bits-1:0]         max_X,
    output logic [Y_bits-1:0]         max_Y
);
    localparam int SW = SIGNAL_bits + 15;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state;
    logic [X_bits-1:0]   x;
    logic [Y_bits-1:0]   y;
    logic [READ_LAT-1:0] vld, vld_n;
    logic [X_bits-1:0]   px [READ_LAT];
    logic [Y_bits-1:0]   py [READ_LAT];
    logic                issue, last, x_end, accept;

    assign accept   = state == IDLE && start;
    assign issue    = state == SCAN && scan_gnt;
    assign x_end    = x == X_bits'(X_DIM - 1);
    assign last     = x_end && y == Y_bits'(Y_DIM - 1);
    // tag pipe after this edge; stage 0 takes the new tag, the top stage retires
    assign vld_n    = (vld << 1) | READ_LAT'(issue);
    assign scan_req = state == SCAN;
    assign busy     = state == SCAN || state == DRAIN;
    assign done     = state == DONE;
    // counter stops on the final cell, so the port holds the last issued address
    assign lookup_X = x;
    assign lookup_Y = y;

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            vld   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            case (state)
                IDLE:    state <= start ? SCAN : IDLE;
                SCAN:    state <= issue && last ? DRAIN : SCAN;
                DRAIN:   state <= vld_n == '0 ? DONE : DRAIN;
                default: state <= IDLE;
            endcase
            if (accept) begin
                x <= '0;
                y <= '0;
            end else if (issue && !last) begin
                x <= x_end ? '0 : x + 1'b1;
                y <= x_end ? y + 1'b1 : y;
            end
            vld   <= vld_n;
            px[0] <= x;
            py[0] <= y;
            for (int i = 1; i < READ_LAT; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            sugar_count <= '0;
            signal_sum  <= '0;
            max_signal  <= '0;
            max_X       <= '0;
            max_Y       <= '0;
        end else if (accept) begin
            sugar_count <= '0;
            signal_sum  <= '0;
            max_signal  <= '0;
            max_X       <= '0;
            max_Y       <= '0;
        end else if (vld[READ_LAT-1]) begin
            sugar_count <= sugar_count + 15'(lookup_sugar);
            signal_sum  <= signal_sum + SW'(lookup_signal);
            // strict compare keeps the earliest raster cell on ties
            if (lookup_signal > max_signal) begin
                max_signal <= lookup_signal;
                max_X      <= px[READ_LAT-1];
                max_Y      <= py[READ_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_env_census.sv
// tb_env_census: directed census runs on a READ_LAT=1 and a READ_LAT=3 instance.
module tb_env_census;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        g1 = 1'b1;
    logic        g3 = 1'b1;
    logic        rnd = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic        smem [32768];
    logic [3:0]  gmem [32768];
    logic [14:0] dl1, dl3a, dl3b, dl3c;

    logic        req1, busy1, done1, sug1;
    logic [7:0]  lx1, mx1;
    logic [6:0]  ly1, my1;
    logic [3:0]  sig1, ms1;
    logic [14:0] sc1;
    logic [18:0] ss1;
    logic        req3, busy3, done3, sug3;
    logic [7:0]  lx3, mx3;
    logic [6:0]  ly3, my3;
    logic [3:0]  sig3, ms3;
    logic [14:0] sc3;
    logic [18:0] ss3;

    int t0, dc1, dc3, dn1, dn3, vis1, vis3, bad1, bad3, den3;
    int ex1, ey1, ex3, ey3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    env_census #(.READ_LAT(1)) u1 (
        .newLocClock(clk), .RESET_SIM(rst), .start(start), .scan_req(req1), .scan_gnt(g1),
        .lookup_X(lx1), .lookup_Y(ly1), .lookup_sugar(sug1), .lookup_signal(sig1),
        .busy(busy1), .done(done1), .sugar_count(sc1), .signal_sum(ss1),
        .max_signal(ms1), .max_X(mx1), .max_Y(my1)
    );
    env_census #(.READ_LAT(3)) u3 (
        .newLocClock(clk), .RESET_SIM(rst), .start(start), .scan_req(req3), .scan_gnt(g3),
        .lookup_X(lx3), .lookup_Y(ly3), .lookup_sugar(sug3), .lookup_signal(sig3),
        .busy(busy3), .done(done3), .sugar_count(sc3), .signal_sum(ss3),
        .max_signal(ms3), .max_X(mx3), .max_Y(my3)
    );

    // environment memory with 1- and 3-cycle read latency
    always @(posedge clk) begin
        dl1  <= {ly1, lx1};
        dl3a <= {ly3, lx3};
        dl3b <= dl3a;
        dl3c <= dl3b;
    end
    assign sug1 = smem[dl1];
    assign sig1 = gmem[dl1];
    assign sug3 = smem[dl3c];
    assign sig3 = gmem[dl3c];

    // scoreboards: raster-order visits, done pulses, denied grant cycles
    always @(negedge clk) begin
        if (start && !busy1 && !done1) begin
            t0 <= cyc; vis1 <= 0; bad1 <= 0; ex1 <= 0; ey1 <= 0; dn1 <= 0;
        end else begin
            if (req1 && g1) begin
                bad1 <= bad1 + ((int'(lx1) != ex1 || int'(ly1) != ey1) ? 1 : 0);
                vis1 <= vis1 + 1;
                ex1  <= ex1 == 159 ? 0 : ex1 + 1;
                ey1  <= ex1 == 159 ? ey1 + 1 : ey1;
            end
            if (done1) begin
                dn1 <= dn1 + 1;
                dc1 <= cyc;
            end
        end
        if (start && !busy3 && !done3) begin
            vis3 <= 0; bad3 <= 0; ex3 <= 0; ey3 <= 0; dn3 <= 0; den3 <= 0;
        end else begin
            if (req3 && g3) begin
                bad3 <= bad3 + ((int'(lx3) != ex3 || int'(ly3) != ey3) ? 1 : 0);
                vis3 <= vis3 + 1;
                ex3  <= ex3 == 159 ? 0 : ex3 + 1;
                ey3  <= ex3 == 159 ? ey3 + 1 : ey3;
            end
            if (req3 && !g3) den3 <= den3 + 1;
            if (done3) begin
                dn3 <= dn3 + 1;
                dc3 <= cyc;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        g3 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // all cells signal 1, no sugar; sugar at three cells; 7s at (10,2),(3,4); 15 at (159,0) if with15
    task automatic load(input bit with15);
        for (int yy = 0; yy < 128; yy++)
            for (int xx = 0; xx < 256; xx++) begin
                smem[yy*256+xx] = 1'b0;
                gmem[yy*256+xx] = 4'd1;
            end
        smem[3*256+5]     = 1'b1;
        smem[119*256+159] = 1'b1;
        smem[0]           = 1'b1;
        gmem[2*256+10]    = 4'd7;
        gmem[4*256+3]     = 4'd7;
        if (with15) gmem[159] = 4'd15;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_both();
        for (int i = 0; i < 60000 && (dn1 == 0 || dn3 == 0); i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        load(1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy1), 0);
        check("rst_req", 32'(req1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_sum", 32'(ss1), 0);
        check("rst_lookup", 32'({ly1, lx1}), 0);

        // run 1: reset 5000 cycles into the scan
        pulse_start();
        repeat (5000) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy1), 1);
        check("mid_sum", 32'(ss1), 5025);
        check("mid_sugar", 32'(sc1), 2);
        rst = 1'b1;
        #1;
        check("mr_busy", 32'({busy1, busy3}), 0);
        check("mr_req", 32'({req1, req3}), 0);
        check("mr_sugar", 32'(sc1), 0);
        check("mr_sum", 32'(ss1), 0);
        check("mr_max", 32'({ms1, mx1, my1}), 0);
        check("mr_lookup", 32'({ly1, lx1}), 0);
        check("mr_u3", 32'({sc3, ss3, ms3}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // run 2: u1 continuous grant, u3 random grant
        rnd = 1'b1;
        pulse_start();
        wait_both();
        rnd = 1'b0;
        check("r2_dn1", 32'(dn1), 1);
        check("r2_lat1", 32'(dc1 - t0), 19202);
        check("r2_vis1", 32'(vis1), 19200);
        check("r2_bad1", 32'(bad1), 0);
        check("r2_sugar1", 32'(sc1), 3);
        check("r2_sum1", 32'(ss1), 19226);
        check("r2_max1", 32'(ms1), 15);
        check("r2_mx1", 32'(mx1), 159);
        check("r2_my1", 32'(my1), 0);
        check("r2_dn3", 32'(dn3), 1);
        check("r2_lat3", 32'(dc3 - t0), 32'(19204 + den3));
        check("r2_vis3", 32'(vis3), 19200);
        check("r2_bad3", 32'(bad3), 0);
        check("r2_sugar3", 32'(sc3), 3);
        check("r2_sum3", 32'(ss3), 19226);
        check("r2_max3", 32'({ms3, mx3, my3}), 32'({4'd15, 8'd159, 7'd0}));

        // run 3: no 15, stray starts during SCAN and during DONE
        load(1'b0);
        pulse_start();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 30000 && !done1; i++) begin
            @(posedge clk);
            #1;
        end
        check("r3_done_seen", 32'(done1), 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_both();
        check("r3_dn1", 32'(dn1), 1);
        check("r3_lat1", 32'(dc1 - t0), 19202);
        check("r3_busy1", 32'(busy1), 0);
        check("r3_req1", 32'(req1), 0);
        check("r3_sugar1", 32'(sc1), 3);
        check("r3_sum1", 32'(ss1), 19212);
        check("r3_max1", 32'(ms1), 7);
        check("r3_mx1", 32'(mx1), 10);
        check("r3_my1", 32'(my1), 2);
        check("r3_vis1", 32'(vis1), 19200);
        check("r3_dn3", 32'(dn3), 1);
        check("r3_lat3", 32'(dc3 - t0), 19204);
        check("r3_sum3", 32'(ss3), 19212);
        check("r3_max3", 32'({ms3, mx3, my3}), 32'({4'd7, 8'd10, 7'd2}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
